// File: rtl/floating_point_divider_if.sv
// Operand/result handshake bundle shared by the FPU arithmetic blocks.
// The master drives operands and arg_vld; the slave returns arg_rdy, result, state and res_vld.
interface floating_point_divider_if;
  logic [31:0] a;
  logic [31:0] b;
  logic        arg_vld;
  logic        arg_rdy;
  logic [31:0] result;
  logic [1:0]  state;
  logic        res_vld;

  modport master (output a, b, arg_vld, input arg_rdy, result, state, res_vld);
  modport slave  (input a, b, arg_vld, output arg_rdy, result, state, res_vld);
endinterface

// File: rtl/floating_point_divider.sv
// Iterative binary32 divider: restoring radix-2 loop, one quotient bit per cycle,
// round-to-nearest-even, subnormals flushed to zero, fixed latency for every operand class.
module floating_point_divider (
  input  logic                           clk,
  input  logic                           rst,
  floating_point_divider_if.slave        bus
);
  localparam int QBITS   = 27;
  localparam int LATENCY = QBITS + 3;
  localparam logic [4:0] LAST_CNT = 5'(LATENCY - 4);

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_NAN = 2'b01;
  localparam logic [1:0] ST_INF = 2'b10;
  localparam logic [1:0] ST_NUL = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_UNPACK, S_DIVIDE, S_NORM} fsm_e;

  fsm_e              r_fsm;
  fsm_e              w_fsm_nxt;
  logic [31:0]       r_a, r_b;
  logic              r_sign;
  logic signed [9:0] r_exp;
  logic [23:0]       r_mb;
  logic [25:0]       r_rem;
  logic [QBITS-1:0]  r_q;
  logic [4:0]        r_cnt;
  logic              r_spec;
  logic [1:0]        r_spec_state;
  logic [31:0]       r_spec_res;
  logic [31:0]       r_result;
  logic [1:0]        r_state;
  logic              r_res_vld;

  logic              w_arg_rdy;
  logic              w_sign;
  logic signed [9:0] w_exp;
  logic              w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan;
  logic              w_spec;
  logic [1:0]        w_spec_state;
  logic [31:0]       w_spec_res;
  logic              w_ge;
  logic [25:0]       w_sub;
  logic              w_sticky, w_g, w_s;
  logic [22:0]       w_frac;
  logic [23:0]       w_frac_rnd;
  logic signed [9:0] w_e_adj, w_e_fin;
  logic [1:0]        w_norm_state;
  logic [31:0]       w_norm_res;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_fsm <= S_IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  // Next-state logic
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE:   if (bus.arg_vld) w_fsm_nxt = S_UNPACK; else w_fsm_nxt = S_IDLE;
      S_UNPACK: w_fsm_nxt = S_DIVIDE;
      S_DIVIDE: if (r_cnt == LAST_CNT) w_fsm_nxt = S_NORM; else w_fsm_nxt = S_DIVIDE;
      S_NORM:   w_fsm_nxt = S_IDLE;
      default:  w_fsm_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_arg_rdy = (r_fsm == S_IDLE);
  end

  // Operand classification and special-case result
  always_comb begin
    w_sign   = r_a[31] ^ r_b[31];
    w_exp    = {2'b00, r_a[30:23]} - {2'b00, r_b[30:23]} + 10'd127;
    w_a_zero = (r_a[30:23] == 8'h00);
    w_b_zero = (r_b[30:23] == 8'h00);
    w_a_inf  = (r_a[30:23] == 8'hFF) && (r_a[22:0] == 23'h0);
    w_b_inf  = (r_b[30:23] == 8'hFF) && (r_b[22:0] == 23'h0);
    w_a_nan  = (r_a[30:23] == 8'hFF) && (r_a[22:0] != 23'h0);
    w_b_nan  = (r_b[30:23] == 8'hFF) && (r_b[22:0] != 23'h0);
    w_spec       = 1'b1;
    w_spec_state = ST_OK;
    w_spec_res   = 32'h0000_0000;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_spec_state = ST_NAN;
      w_spec_res   = 32'h7FC0_0000;
    end else if (w_a_inf || w_b_zero) begin
      w_spec_state = ST_INF;
      w_spec_res   = {w_sign, 8'hFF, 23'h0};
    end else if (w_a_zero || w_b_inf) begin
      w_spec_state = ST_NUL;
      w_spec_res   = {w_sign, 31'h0};
    end else begin
      w_spec = 1'b0;
    end
  end

  // One restoring-division step
  always_comb begin
    w_ge = (r_rem >= {2'b00, r_mb});
    if (w_ge) w_sub = r_rem - {2'b00, r_mb};
    else      w_sub = r_rem;
  end

  // Normalise, round to nearest-even and range-check the quotient
  always_comb begin
    w_sticky = (r_rem != 26'h0);
    if (r_q[26]) begin
      w_frac  = r_q[25:3];
      w_g     = r_q[2];
      w_s     = (|r_q[1:0]) | w_sticky;
      w_e_adj = r_exp;
    end else begin
      w_frac  = r_q[24:2];
      w_g     = r_q[1];
      w_s     = r_q[0] | w_sticky;
      w_e_adj = r_exp - 10'sd1;
    end
    // a carry out of the fraction means the mantissa became exactly 2.0
    w_frac_rnd = {1'b0, w_frac} + {23'h0, w_g & (w_s | w_frac[0])};
    if (w_frac_rnd[23]) w_e_fin = w_e_adj + 10'sd1;
    else                w_e_fin = w_e_adj;
    if (w_e_fin >= 10'sd255) begin
      w_norm_state = ST_INF;
      w_norm_res   = {r_sign, 8'hFF, 23'h0};
    end else if (w_e_fin <= 10'sd0) begin
      w_norm_state = ST_NUL;
      w_norm_res   = {r_sign, 31'h0};
    end else begin
      w_norm_state = ST_OK;
      w_norm_res   = {r_sign, w_e_fin[7:0], w_frac_rnd[22:0]};
    end
  end

  // Datapath registers and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= 5'd0;
      r_result  <= 32'h0000_0000;
      r_state   <= ST_OK;
      r_res_vld <= 1'b0;
    end else begin
      r_res_vld <= 1'b0;
      case (r_fsm)
        S_IDLE: begin
          if (bus.arg_vld) begin
            r_a <= bus.a;
            r_b <= bus.b;
          end
        end
        S_UNPACK: begin
          r_sign       <= w_sign;
          r_exp        <= w_exp;
          r_mb         <= {1'b1, r_b[22:0]};
          r_rem        <= {3'b001, r_a[22:0]};
          r_q          <= '0;
          r_cnt        <= 5'd0;
          r_spec       <= w_spec;
          r_spec_state <= w_spec_state;
          r_spec_res   <= w_spec_res;
        end
        S_DIVIDE: begin
          r_q   <= {r_q[QBITS-2:0], w_ge};
          r_rem <= w_sub << 1;
          r_cnt <= r_cnt + 5'd1;
        end
        S_NORM: begin
          r_res_vld <= 1'b1;
          if (r_spec) begin
            r_result <= r_spec_res;
            r_state  <= r_spec_state;
          end else begin
            r_result <= w_norm_res;
            r_state  <= w_norm_state;
          end
        end
        default: r_res_vld <= 1'b0;
      endcase
    end
  end

  assign bus.arg_rdy = w_arg_rdy;
  assign bus.result  = r_result;
  assign bus.state   = r_state;
  assign bus.res_vld = r_res_vld;
endmodule
